// File: rtl/bvh_stream_loader_if.sv
// Byte-stream link from the SD file reader into the BVH loader.
// One byte per in_valid strobe, in_last marks the final byte of the file, no backpressure.
interface bvh_stream_loader_if;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_last;

  modport master (output in_valid, in_byte, in_last);
  modport slave  (input  in_valid, in_byte, in_last);
endinterface

// File: rtl/bvh_stream_loader.sv
// Assembles the SD byte stream (big-endian node count, node records, leaf records) into BVH RAM writes.
// Optional BVH_LOADER_CHECKSUM_EN: final byte is a mod-256 sum check and checksum_calc is exported.
module bvh_stream_loader #(
  parameter int NODE_BYTES = 28,
  parameter int LEAF_BYTES = 5,
  parameter int NODE_DEPTH = 1024,
  parameter int LEAF_DEPTH = 1024,
  localparam int NODE_AW = $clog2(NODE_DEPTH),
  localparam int LEAF_AW = $clog2(LEAF_DEPTH),
  localparam int NODE_W  = NODE_BYTES * 8,
  localparam int LEAF_W  = LEAF_BYTES * 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  bvh_stream_loader_if.slave  s_in,
  output logic                node_we,
  output logic [NODE_AW-1:0]  node_waddr,
  output logic [NODE_W-1:0]   node_wdata,
  output logic                leaf_we,
  output logic [LEAF_AW-1:0]  leaf_waddr,
  output logic [LEAF_W-1:0]   leaf_wdata,
  output logic [15:0]         node_count,
  output logic [15:0]         leaf_count,
  output logic                init_done,
  output logic                error
`ifdef BVH_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]          checksum_calc
`endif
);

  localparam int MAX_BYTES = (NODE_BYTES > LEAF_BYTES) ? NODE_BYTES : LEAF_BYTES;
  localparam int BCW = $clog2(MAX_BYTES);

  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, NODES, LEAVES, DONE, ERROR
  } state_t;

  state_t            state, state_next;
  logic [BCW-1:0]    byte_cnt;
  logic [NODE_W-1:0] asm_reg;
  logic [15:0]       node_total;
  logic [15:0]       hdr_n;
  logic              node_wr, leaf_wr, shift_en, rec_end, sum_en;

  assign hdr_n = {node_total[15:8], s_in.in_byte};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    node_wr    = 1'b0;
    leaf_wr    = 1'b0;
    shift_en   = 1'b0;
    rec_end    = 1'b0;
    sum_en     = 1'b0;
    if (start) begin
      state_next = HDR_HI;
    end else if (s_in.in_valid) begin
      unique case (state)
        HDR_HI: begin
          sum_en     = !s_in.in_last;
          state_next = s_in.in_last ? ERROR : HDR_LO;
        end
        HDR_LO: begin
          sum_en = !s_in.in_last;
          if (s_in.in_last || ({1'b0, hdr_n} > 17'(NODE_DEPTH))) state_next = ERROR;
          else if (hdr_n == 16'd0)                                 state_next = LEAVES;
          else                                                     state_next = NODES;
        end
        NODES: begin
          if (s_in.in_last) begin
            state_next = ERROR;
          end else begin
            sum_en   = 1'b1;
            shift_en = 1'b1;
            rec_end  = (byte_cnt == BCW'(NODE_BYTES - 1));
            if (rec_end) begin
              node_wr = 1'b1;
              if (node_count == node_total - 16'd1) state_next = LEAVES;
            end
          end
        end
        LEAVES: begin
`ifdef BVH_LOADER_CHECKSUM_EN
          // The in_last byte carries the checksum and is only legal between leaf records.
          if (s_in.in_last) begin
            state_next = ((byte_cnt == '0) && (s_in.in_byte == checksum_calc)) ? DONE : ERROR;
          end else begin
            sum_en   = 1'b1;
            shift_en = 1'b1;
            rec_end  = (byte_cnt == BCW'(LEAF_BYTES - 1));
            if (rec_end) begin
              if ({1'b0, leaf_count} >= 17'(LEAF_DEPTH)) state_next = ERROR;
              else                                       leaf_wr = 1'b1;
            end
          end
`else
          sum_en   = 1'b1;
          shift_en = 1'b1;
          rec_end  = (byte_cnt == BCW'(LEAF_BYTES - 1));
          if (rec_end) begin
            if ({1'b0, leaf_count} >= 17'(LEAF_DEPTH)) state_next = ERROR;
            else begin
              leaf_wr = 1'b1;
              if (s_in.in_last) state_next = DONE;
            end
          end else if (s_in.in_last) begin
            state_next = ERROR;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // init_done trails entry to DONE by one cycle so it lands after the final leaf_we.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      node_we    <= 1'b0;
      node_waddr <= '0;
      node_wdata <= '0;
      leaf_we    <= 1'b0;
      leaf_waddr <= '0;
      leaf_wdata <= '0;
      node_count <= '0;
      leaf_count <= '0;
      init_done  <= 1'b0;
      error      <= 1'b0;
      byte_cnt   <= '0;
      asm_reg    <= '0;
      node_total <= '0;
`ifdef BVH_LOADER_CHECKSUM_EN
      checksum_calc <= '0;
`endif
    end else begin
      node_we   <= node_wr;
      leaf_we   <= leaf_wr;
      error     <= (state_next == ERROR);
      init_done <= (state == DONE) && !start;
      if (start) begin
        node_count <= '0;
        leaf_count <= '0;
        byte_cnt   <= '0;
        asm_reg    <= '0;
        node_total <= '0;
`ifdef BVH_LOADER_CHECKSUM_EN
        checksum_calc <= '0;
`endif
      end else if (s_in.in_valid) begin
        if (state == HDR_HI) node_total[15:8] <= s_in.in_byte;
        if (state == HDR_LO) node_total[7:0]  <= s_in.in_byte;
        if (shift_en) begin
          if (rec_end) begin
            byte_cnt <= '0;
            asm_reg  <= '0;
          end else begin
            byte_cnt <= byte_cnt + BCW'(1);
            asm_reg  <= {asm_reg[NODE_W-9:0], s_in.in_byte};
          end
        end
        if (node_wr) begin
          node_waddr <= node_count[NODE_AW-1:0];
          node_wdata <= {asm_reg[NODE_W-9:0], s_in.in_byte};
          node_count <= node_count + 16'd1;
        end
        if (leaf_wr) begin
          leaf_waddr <= leaf_count[LEAF_AW-1:0];
          leaf_wdata <= {asm_reg[LEAF_W-9:0], s_in.in_byte};
          leaf_count <= leaf_count + 16'd1;
        end
`ifdef BVH_LOADER_CHECKSUM_EN
        if (sum_en) checksum_calc <= checksum_calc + s_in.in_byte;
`endif
      end
    end
  end

`ifndef BVH_LOADER_CHECKSUM_EN
  logic unused_sum_en;
  assign unused_sum_en = sum_en;
`endif

endmodule

// File: tb/tb_bvh_stream_loader.sv
// Scoreboard bench for bvh_stream_loader: expected RAM writes are queued as bytes are driven.
// Works with or without BVH_LOADER_CHECKSUM_EN.
module tb_bvh_stream_loader;

  localparam int NODE_BYTES = 28;
  localparam int LEAF_BYTES = 5;

  typedef struct {
    logic [15:0]  addr;
    logic [223:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic         node_we, leaf_we, init_done, error;
  logic [9:0]   node_waddr, leaf_waddr;
  logic [223:0] node_wdata;
  logic [39:0]  leaf_wdata;
  logic [15:0]  node_count, leaf_count;
`ifdef BVH_LOADER_CHECKSUM_EN
  logic [7:0]   checksum_calc;
`endif

  int  check_count = 0;
  int  fail_count = 0;
  wr_t node_q[$];
  wr_t leaf_q[$];
  wr_t mon_e;
  logic [223:0] cap_node0 = '0;
  logic [39:0]  cap_leaf0 = '0;
  logic         prev_leaf_we = 1'b0;
  logic         prev_init_done = 1'b0;
  logic [7:0]   last_sum = 8'h00;
  logic [7:0]   leaf0_bytes [LEAF_BYTES] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h03};

  bvh_stream_loader_if bus();

  bvh_stream_loader dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .s_in       (bus),
    .node_we    (node_we),
    .node_waddr (node_waddr),
    .node_wdata (node_wdata),
    .leaf_we    (leaf_we),
    .leaf_waddr (leaf_waddr),
    .leaf_wdata (leaf_wdata),
    .node_count (node_count),
    .leaf_count (leaf_count),
    .init_done  (init_done),
    .error      (error)
`ifdef BVH_LOADER_CHECKSUM_EN
    ,
    .checksum_calc (checksum_calc)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drives one byte for one cycle starting just after a rising edge, then an optional idle gap.
  task automatic applyStimulus(input logic [7:0] b, input logic last, input int max_gap);
    int k;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.in_last  = last;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    k = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic pulseStart(input logic with_byte);
    start        = 1'b1;
    bus.in_valid = with_byte;
    bus.in_byte  = 8'hFF;
    @(posedge clk); #1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic loadImage(input int n_nodes, input int n_leaves, input bit directed,
                           input int max_gap, input bit bad_sum);
    logic [15:0] nn;
    logic [7:0]  b, sum;
    logic        last;
    wr_t         e;
    nn  = 16'(n_nodes);
    sum = 8'h00;
    applyStimulus(nn[15:8], 1'b0, max_gap); sum = sum + nn[15:8];
    applyStimulus(nn[7:0],  1'b0, max_gap); sum = sum + nn[7:0];
    for (int i = 0; i < n_nodes; i++) begin
      e.addr = 16'(i);
      e.data = '0;
      for (int j = 0; j < NODE_BYTES; j++) begin
        b = directed ? 8'(i * NODE_BYTES + j + 1) : 8'($urandom);
        e.data[(NODE_BYTES-1-j)*8 +: 8] = b;
        if (j == NODE_BYTES - 1) node_q.push_back(e);
        applyStimulus(b, 1'b0, max_gap);
        sum = sum + b;
      end
    end
    for (int i = 0; i < n_leaves; i++) begin
      e.addr = 16'(i);
      e.data = '0;
      for (int j = 0; j < LEAF_BYTES; j++) begin
        b = (directed && i == 0) ? leaf0_bytes[j] : 8'($urandom);
        e.data[(LEAF_BYTES-1-j)*8 +: 8] = b;
        last = (i == n_leaves - 1) && (j == LEAF_BYTES - 1);
`ifdef BVH_LOADER_CHECKSUM_EN
        last = 1'b0;
`endif
        if (j == LEAF_BYTES - 1) leaf_q.push_back(e);
        applyStimulus(b, last, max_gap);
        sum = sum + b;
      end
    end
    last_sum = sum;
`ifdef BVH_LOADER_CHECKSUM_EN
    applyStimulus(bad_sum ? sum + 8'd1 : sum, 1'b1, 0);
`else
    if (bad_sum) $display("[TB] note: bad_sum ignored without checksum");
`endif
  endtask

  task automatic waitEnd();
    int n;
    n = 0;
    while (!(init_done || error) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("end_timeout", 256'(n < 50), 256'd1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic checkImage(input int n_nodes, input int n_leaves, input bit ok);
    checkOutput("node_count", node_count, 256'(n_nodes));
    checkOutput("leaf_count", leaf_count, 256'(n_leaves));
    checkOutput("init_done", init_done, 256'(ok));
    checkOutput("error", error, 256'(!ok));
    checkOutput("node_q_drained", 256'(node_q.size()), 256'd0);
    checkOutput("leaf_q_drained", 256'(leaf_q.size()), 256'd0);
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resetn) begin
      if (node_we && leaf_we) checkOutput("we_exclusive", 256'd1, 256'd0);
      if (init_done && error) checkOutput("done_err_exclusive", 256'd1, 256'd0);
      if (node_we) begin
        if (node_q.size() == 0) checkOutput("node_unexpected", 256'd1, 256'd0);
        else begin
          mon_e = node_q.pop_front();
          checkOutput("node_waddr", node_waddr, mon_e.addr);
          checkOutput("node_wdata", node_wdata, mon_e.data);
        end
        if (node_waddr == 10'd0) cap_node0 = node_wdata;
      end
      if (leaf_we) begin
        if (leaf_q.size() == 0) checkOutput("leaf_unexpected", 256'd1, 256'd0);
        else begin
          mon_e = leaf_q.pop_front();
          checkOutput("leaf_waddr", leaf_waddr, mon_e.addr);
          checkOutput("leaf_wdata", leaf_wdata, mon_e.data);
        end
        if (leaf_waddr == 10'd0) cap_leaf0 = leaf_wdata;
      end
`ifndef BVH_LOADER_CHECKSUM_EN
      if (init_done && !prev_init_done) checkOutput("done_after_leaf_we", prev_leaf_we, 256'd1);
`endif
    end
    prev_leaf_we   = leaf_we;
    prev_init_done = init_done;
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    bus.in_last  = 1'b0;
    #12;
    checkOutput("rst_node_we", node_we, 256'd0);
    checkOutput("rst_leaf_we", leaf_we, 256'd0);
    checkOutput("rst_counts", {node_count, leaf_count}, 256'd0);
    checkOutput("rst_flags", {init_done, error}, 256'd0);
    #10 resetn = 1'b1;
    @(posedge clk); #1;

    // Two nodes, two leaves, directed bytes
    pulseStart(1'b0);
    loadImage(2, 2, 1'b1, 0, 1'b0);
    waitEnd();
    checkImage(2, 2, 1'b1);
    checkOutput("node0_literal", cap_node0,
                256'(224'h0102030405060708090A0B0C0D0E0F101112131415161718191A1B1C));
    checkOutput("leaf0_literal", cap_leaf0, 256'(40'hAABBCCDD03));
`ifdef BVH_LOADER_CHECKSUM_EN
    checkOutput("checksum_calc", checksum_calc, 256'(last_sum));
`endif

    // Start arriving together with a byte drops that byte; zero-node image
    pulseStart(1'b1);
    checkOutput("start_clears", {node_count, leaf_count, 6'd0, init_done, error}, 256'd0);
    loadImage(0, 1, 1'b0, 0, 1'b0);
    waitEnd();
    checkImage(0, 1, 1'b1);

    // Oversized node count: error after header, nothing written afterwards
    pulseStart(1'b0);
    applyStimulus(8'h04, 1'b0, 0);
    applyStimulus(8'h01, 1'b0, 0);
    checkOutput("big_n_error", error, 256'd1);
    for (int i = 0; i < 40; i++) applyStimulus(8'($urandom), 1'b0, 0);
    checkImage(0, 0, 1'b0);

    // in_last mid-leaf: error, partial leaf discarded
    pulseStart(1'b0);
    applyStimulus(8'h00, 1'b0, 0);
    applyStimulus(8'h00, 1'b0, 0);
    applyStimulus(8'h11, 1'b0, 0);
    applyStimulus(8'h22, 1'b0, 0);
    applyStimulus(8'h33, 1'b1, 0);
    repeat (3) begin @(posedge clk); #1; end
    checkImage(0, 0, 1'b0);
    pulseStart(1'b0);
    checkOutput("restart_clears", {node_count, leaf_count, 6'd0, init_done, error}, 256'd0);
`ifdef BVH_LOADER_CHECKSUM_EN
    checkOutput("restart_sum", checksum_calc, 256'd0);
`endif
    loadImage(1, 3, 1'b0, 2, 1'b0);
    waitEnd();
    checkImage(1, 3, 1'b1);

    // Start in the middle of a node record aborts it cleanly
    pulseStart(1'b0);
    applyStimulus(8'h00, 1'b0, 0);
    applyStimulus(8'h03, 1'b0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(8'($urandom), 1'b0, 0);
    pulseStart(1'b1);
    loadImage(3, 2, 1'b0, 0, 1'b0);
    waitEnd();
    checkImage(3, 2, 1'b1);

    // Reset landing on the completing node byte: no strobe may follow
    pulseStart(1'b0);
    applyStimulus(8'h00, 1'b0, 0);
    applyStimulus(8'h01, 1'b0, 0);
    for (int i = 0; i < NODE_BYTES - 1; i++) applyStimulus(8'($urandom), 1'b0, 0);
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h5A;
    #2 resetn = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checkOutput("reset_no_we", {node_we, leaf_we}, 256'd0);
    checkOutput("reset_counts", {node_count, leaf_count}, 256'd0);
    #3 resetn = 1'b1;
    @(posedge clk); #1;

`ifdef BVH_LOADER_CHECKSUM_EN
    pulseStart(1'b0);
    loadImage(2, 2, 1'b1, 0, 1'b0);
    waitEnd();
    checkImage(2, 2, 1'b1);
    pulseStart(1'b0);
    loadImage(2, 2, 1'b1, 0, 1'b1);
    waitEnd();
    checkImage(2, 2, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
